bnn_layer_sequencer: RTL and testbench

- Schedules the fully-connected binary layers of the `bnn` accelerator. Holds a per-layer config table and steps weight/activation reads through the XNOR-popcount datapath.
- Generates accumulator control (clear/enable/last) and binarized-output writeback into a ping-pong activation buffer.
- Reports completion with a single-cycle `done` pulse.
- Sits between the top-level `start`/`done` handshake and the datapath/memories.

---
 rtl/bnn_layer_sequencer_if.sv | 44 ++++
 rtl/bnn_layer_sequencer.sv | 177 +++++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_layer_sequencer_if.sv
// Control bus between the bnn host/datapath and the layer sequencer.
// master drives start and config writes; slave (the sequencer) drives everything else.
interface bnn_layer_sequencer_if #(
   parameter int NUM_LAYERS = 3,
   parameter int WORDS_W    = 8,
   parameter int NEUR_W     = 10,
   parameter int ADDR_W     = 11,
   parameter int WADDR_W    = 16
);
   localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   logic               start;
   logic               cfg_wr_en;
   logic [LAYER_W-1:0] cfg_layer;
   logic [WORDS_W-1:0] cfg_in_words;
   logic [NEUR_W-1:0]  cfg_neurons;
   logic               act_rd_en;
   logic [ADDR_W-1:0]  act_rd_addr;
   logic               wgt_rd_en;
   logic [WADDR_W-1:0] wgt_rd_addr;
   logic               acc_clr;
   logic               acc_en;
   logic               acc_last;
   logic               out_wr_en;
   logic [NEUR_W-1:0]  out_wr_addr;
   logic               act_bank;
   logic               final_layer;
   logic [LAYER_W-1:0] layer_idx;
   logic               busy;
   logic               done;
   logic [31:0]        perf_cycles;

   modport master (
      output start, cfg_wr_en, cfg_layer, cfg_in_words, cfg_neurons,
      input  act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr, acc_clr, acc_en, acc_last,
             out_wr_en, out_wr_addr, act_bank, final_layer, layer_idx, busy, done, perf_cycles
   );

   modport slave (
      input  start, cfg_wr_en, cfg_layer, cfg_in_words, cfg_neurons,
      output act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr, acc_clr, acc_en, acc_last,
             out_wr_en, out_wr_addr, act_bank, final_layer, layer_idx, busy, done, perf_cycles
   );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Layer scheduler for the bnn XNOR-popcount datapath: config table, read stepping,
// accumulator control and ping-pong writeback. Define BNN_SEQ_PERF_EN for the cycle counter.
module bnn_layer_sequencer #(
   parameter int NUM_LAYERS = 3,
   parameter int WORDS_W    = 8,
   parameter int NEUR_W     = 10,
   parameter int ADDR_W     = 11,
   parameter int WADDR_W    = 16
) (
   input logic                  clk,
   input logic                  rst,
   bnn_layer_sequencer_if.slave bus
);
   localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

   state_t             state;
   logic [WORDS_W-1:0] tbl_words   [NUM_LAYERS];
   logic [NEUR_W-1:0]  tbl_neurons [NUM_LAYERS];
   logic [WORDS_W-1:0] w_cnt;
   logic [NEUR_W-1:0]  n_cnt;
   logic               rd_last_word;
   logic [NEUR_W-1:0]  acc_n;
   logic               drain_second;
   logic               later_live;
   logic               last_slot;
   logic [WORDS_W-1:0] cur_words;
   logic [NEUR_W-1:0]  cur_neurons;

   assign cur_words   = tbl_words[bus.layer_idx];
   assign cur_neurons = tbl_neurons[bus.layer_idx];
   assign last_slot   = (int'(bus.layer_idx) == NUM_LAYERS - 1);

   // A layer is final when no later slot holds a non-empty layer.
   always_comb begin
      later_live = 1'b0;
      for (int j = 0; j < NUM_LAYERS; j++) begin
         if (j > int'(bus.layer_idx) && tbl_words[j] != '0 && tbl_neurons[j] != '0)
            later_live = 1'b1;
      end
   end

   // Single FSM; the acc and writeback stages trail the read strobe by one and two cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            tbl_words[i]   <= '0;
            tbl_neurons[i] <= '0;
         end
         w_cnt           <= '0;
         n_cnt           <= '0;
         rd_last_word    <= 1'b0;
         acc_n           <= '0;
         drain_second    <= 1'b0;
         bus.act_rd_en   <= 1'b0;
         bus.act_rd_addr <= '0;
         bus.wgt_rd_en   <= 1'b0;
         bus.wgt_rd_addr <= '0;
         bus.acc_clr     <= 1'b0;
         bus.acc_en      <= 1'b0;
         bus.acc_last    <= 1'b0;
         bus.out_wr_en   <= 1'b0;
         bus.out_wr_addr <= '0;
         bus.act_bank    <= 1'b0;
         bus.final_layer <= 1'b0;
         bus.layer_idx   <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
      end else begin
         bus.acc_en      <= bus.act_rd_en;
         bus.acc_clr     <= bus.act_rd_en && (w_cnt == '0);
         bus.acc_last    <= bus.act_rd_en && rd_last_word;
         acc_n           <= n_cnt;
         bus.out_wr_en   <= bus.acc_last;
         bus.out_wr_addr <= acc_n;
         bus.done        <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.cfg_wr_en && int'(bus.cfg_layer) < NUM_LAYERS) begin
                  tbl_words[bus.cfg_layer]   <= bus.cfg_in_words;
                  tbl_neurons[bus.cfg_layer] <= bus.cfg_neurons;
               end
               if (bus.start) begin
                  state           <= LOAD;
                  bus.layer_idx   <= '0;
                  bus.wgt_rd_addr <= '0;
                  bus.act_bank    <= 1'b0;
                  bus.final_layer <= 1'b0;
                  bus.busy        <= 1'b1;
               end
            end

            LOAD: begin
               if (cur_words == '0 || cur_neurons == '0) begin
                  if (last_slot) begin
                     state    <= DONE;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end else begin
                     bus.layer_idx <= bus.layer_idx + LAYER_W'(1);
                  end
               end else begin
                  w_cnt           <= '0;
                  n_cnt           <= '0;
                  rd_last_word    <= (cur_words == WORDS_W'(1));
                  bus.act_rd_en   <= 1'b1;
                  bus.wgt_rd_en   <= 1'b1;
                  bus.act_rd_addr <= '0;
                  bus.final_layer <= !later_live;
                  state           <= RUN;
               end
            end

            RUN: begin
               bus.wgt_rd_addr <= bus.wgt_rd_addr + WADDR_W'(1);
               if (rd_last_word && n_cnt == cur_neurons - NEUR_W'(1)) begin
                  bus.act_rd_en <= 1'b0;
                  bus.wgt_rd_en <= 1'b0;
                  drain_second  <= 1'b0;
                  state         <= DRAIN;
               end else if (rd_last_word) begin
                  w_cnt           <= '0;
                  n_cnt           <= n_cnt + NEUR_W'(1);
                  bus.act_rd_addr <= '0;
                  rd_last_word    <= (cur_words == WORDS_W'(1));
               end else begin
                  w_cnt           <= w_cnt + WORDS_W'(1);
                  bus.act_rd_addr <= ADDR_W'(w_cnt + WORDS_W'(1));
                  rd_last_word    <= (w_cnt + WORDS_W'(1) == cur_words - WORDS_W'(1));
               end
            end

            // Two idle cycles let the last word's acc and writeback stages retire.
            DRAIN: begin
               if (!drain_second) begin
                  drain_second <= 1'b1;
               end else begin
                  bus.act_bank <= ~bus.act_bank;
                  if (last_slot) begin
                     state    <= DONE;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end else begin
                     bus.layer_idx <= bus.layer_idx + LAYER_W'(1);
                     state         <= LOAD;
                  end
               end
            end

            DONE: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

`ifdef BNN_SEQ_PERF_EN
   logic [31:0] perf_cnt;

   // Counts every busy cycle plus the DONE cycle, then holds until the next accepted start.
   always_ff @(posedge clk) begin
      if (rst)
         perf_cnt <= '0;
      else if (state == IDLE && bus.start)
         perf_cnt <= '0;
      else if ((bus.busy || state == DONE) && perf_cnt != '1)
         perf_cnt <= perf_cnt + 32'd1;
   end

   assign bus.perf_cycles = perf_cnt;
`else
   assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: a timeline model of each run fills per-stream queues,
// and a negedge monitor pops and compares whatever the sequencer strobes.
module tb_bnn_layer_sequencer;
   localparam int NUM_LAYERS = 3;
   localparam int WORDS_W    = 8;
   localparam int NEUR_W     = 10;
   localparam int ADDR_W     = 11;
   localparam int WADDR_W    = 16;

   typedef struct {int cyc; int w; int wa; int layer; int bank; int fin;} rd_exp_t;
   typedef struct {int cyc; int clr; int last;} acc_exp_t;
   typedef struct {int cyc; int n; int layer; int bank;} wr_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   start_cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   done_exp_cyc = 0;
   int   done_rel = -1;
   int   clr_count = 0;
   int   mon_rel;
   bit   done_armed = 1'b0;
   bit   done_seen = 1'b0;
   int   sh_words [NUM_LAYERS];
   int   sh_neur  [NUM_LAYERS];

   rd_exp_t  rd_q[$];
   acc_exp_t acc_q[$];
   wr_exp_t  wr_q[$];
   rd_exp_t  mon_rd;
   acc_exp_t mon_acc;
   wr_exp_t  mon_wr;

   bnn_layer_sequencer_if #(
      .NUM_LAYERS(NUM_LAYERS), .WORDS_W(WORDS_W), .NEUR_W(NEUR_W),
      .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)
   ) bus ();

   bnn_layer_sequencer #(
      .NUM_LAYERS(NUM_LAYERS), .WORDS_W(WORDS_W), .NEUR_W(NEUR_W),
      .ADDR_W(ADDR_W), .WADDR_W(WADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual == expected)
         passes++;
      else
         $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d after start)", name, actual, expected, cyc - start_cyc);
   endtask

   // Pops the expected event for every strobe the sequencer raises.
   always @(negedge clk) begin
      if (!rst) begin
         mon_rel = cyc - start_cyc;
         if (bus.act_rd_en || bus.wgt_rd_en) begin
            if (rd_q.size() == 0) begin
               checkOutput("read strobes outside schedule", {bus.act_rd_en, bus.wgt_rd_en}, 0);
            end else begin
               mon_rd = rd_q.pop_front();
               checkOutput("read cycle", mon_rel, mon_rd.cyc);
               checkOutput("act/wgt read strobes", {bus.act_rd_en, bus.wgt_rd_en}, 3);
               checkOutput("act_rd_addr", bus.act_rd_addr, mon_rd.w);
               checkOutput("wgt_rd_addr", bus.wgt_rd_addr, mon_rd.wa);
               checkOutput("read layer_idx", bus.layer_idx, mon_rd.layer);
               checkOutput("read act_bank", bus.act_bank, mon_rd.bank);
               checkOutput("final_layer", bus.final_layer, mon_rd.fin);
            end
         end
         if (bus.acc_en || bus.acc_clr || bus.acc_last) begin
            clr_count += int'(bus.acc_clr);
            if (acc_q.size() == 0) begin
               checkOutput("acc strobes outside schedule", {bus.acc_en, bus.acc_clr, bus.acc_last}, 0);
            end else begin
               mon_acc = acc_q.pop_front();
               checkOutput("acc cycle", mon_rel, mon_acc.cyc);
               checkOutput("acc_en", bus.acc_en, 1);
               checkOutput("acc_clr", bus.acc_clr, mon_acc.clr);
               checkOutput("acc_last", bus.acc_last, mon_acc.last);
            end
         end
         if (bus.out_wr_en) begin
            if (wr_q.size() == 0) begin
               checkOutput("out_wr_en outside schedule", bus.out_wr_en, 0);
            end else begin
               mon_wr = wr_q.pop_front();
               checkOutput("write cycle", mon_rel, mon_wr.cyc);
               checkOutput("out_wr_addr", bus.out_wr_addr, mon_wr.n);
               checkOutput("write layer_idx", bus.layer_idx, mon_wr.layer);
               checkOutput("write act_bank", bus.act_bank, mon_wr.bank);
            end
         end
         if (bus.done) begin
            if (!done_armed) begin
               checkOutput("done outside run", bus.done, 0);
            end else begin
               done_rel = mon_rel;
               checkOutput("done cycle", mon_rel, done_exp_cyc);
               checkOutput("busy during done", bus.busy, 0);
               done_armed = 1'b0;
               done_seen  = 1'b1;
            end
         end
      end
   end

   // Timeline model: LOAD costs one cycle, reads follow back to back, then two drain cycles.
   task automatic buildExpected();
      int t, wa, bank, last_ne, rc;
      last_ne = -1;
      for (int l = 0; l < NUM_LAYERS; l++)
         if (sh_words[l] != 0 && sh_neur[l] != 0) last_ne = l;
      t = 1; wa = 0; bank = 0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
         if (sh_words[l] == 0 || sh_neur[l] == 0) begin
            t++;
            continue;
         end
         for (int n = 0; n < sh_neur[l]; n++) begin
            for (int w = 0; w < sh_words[l]; w++) begin
               rc = t + 1 + n * sh_words[l] + w;
               rd_q.push_back('{rc, w, wa % 65536, l, bank, int'(l == last_ne)});
               acc_q.push_back('{rc + 1, int'(w == 0), int'(w == sh_words[l] - 1)});
               if (w == sh_words[l] - 1) wr_q.push_back('{rc + 2, n, l, bank});
               wa++;
            end
         end
         t += 1 + sh_words[l] * sh_neur[l] + 2;
         bank ^= 1;
      end
      done_exp_cyc = t;
      done_seen    = 1'b0;
      done_armed   = 1'b1;
   endtask

   task automatic writeCfg(input int layer, input int words, input int neur);
      @(posedge clk); #1;
      bus.cfg_wr_en    = 1'b1;
      bus.cfg_layer    = 2'(layer);
      bus.cfg_in_words = 8'(words);
      bus.cfg_neurons  = 10'(neur);
      @(posedge clk); #1;
      bus.cfg_wr_en = 1'b0;
      sh_words[layer] = words;
      sh_neur[layer]  = neur;
   endtask

   task automatic applyStimulus();
      buildExpected();
      @(posedge clk); #1;
      bus.start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      for (int i = 0; i < 300 && !done_seen; i++) @(posedge clk);
      checkOutput({tag, " done within budget"}, done_seen, 1);
      #1;
      checkOutput({tag, " busy after done"}, bus.busy, 0);
`ifdef BNN_SEQ_PERF_EN
      checkOutput({tag, " perf_cycles"}, bus.perf_cycles, done_exp_cyc);
`else
      checkOutput({tag, " perf_cycles"}, bus.perf_cycles, 0);
`endif
      checkOutput({tag, " reads left unissued"}, rd_q.size(), 0);
      checkOutput({tag, " acc cycles left unissued"}, acc_q.size(), 0);
      checkOutput({tag, " writes left unissued"}, wr_q.size(), 0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " strobes"}, {bus.act_rd_en, bus.wgt_rd_en, bus.acc_clr, bus.acc_en,
                                      bus.acc_last, bus.out_wr_en, bus.done, bus.busy}, 0);
      checkOutput({tag, " act_rd_addr"}, bus.act_rd_addr, 0);
      checkOutput({tag, " wgt_rd_addr"}, bus.wgt_rd_addr, 0);
      checkOutput({tag, " out_wr_addr"}, bus.out_wr_addr, 0);
      checkOutput({tag, " bank/final/layer"}, {bus.act_bank, bus.final_layer, bus.layer_idx}, 0);
      checkOutput({tag, " perf_cycles"}, bus.perf_cycles, 0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.cfg_wr_en = 1'b0;
      bus.cfg_layer = '0;
      bus.cfg_in_words = '0;
      bus.cfg_neurons = '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
         sh_words[l] = 0;
         sh_neur[l]  = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkAllZero("reset");

      // Empty table: three skipped slots, then DONE.
      applyStimulus();
      waitDone("empty");
      checkOutput("empty run done cycle", done_rel, 4);

      writeCfg(0, 2, 3);
      applyStimulus();
      waitDone("2x3");
      checkOutput("2x3 done cycle", done_rel, 12);

      writeCfg(0, 2, 4);
      writeCfg(1, 1, 3);
      writeCfg(2, 1, 2);
      clr_count = 0;
      applyStimulus();
      begin
         bit found = 1'b0;
         for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.layer_idx == 2'd1 && bus.act_rd_en) found = 1'b1;
         end
         checkOutput("reached layer 1 reads", found, 1);
      end
      bus.start = 1'b1;
      bus.cfg_wr_en = 1'b1;
      bus.cfg_layer = 2'd0;
      bus.cfg_in_words = 8'd5;
      bus.cfg_neurons = 10'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.cfg_wr_en = 1'b0;
      waitDone("three layers");
      checkOutput("three layers done cycle", done_rel, 23);
      checkOutput("three layers acc_clr count", clr_count, 9);

      // Same schedule again shows the mid-run config write never landed.
      applyStimulus();
      waitDone("three layers rerun");
      checkOutput("rerun done cycle", done_rel, 23);

      applyStimulus();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rd_q.delete();
      acc_q.delete();
      wr_q.delete();
      done_armed = 1'b0;
      checkAllZero("mid-run reset");
      for (int l = 0; l < NUM_LAYERS; l++) begin
         sh_words[l] = 0;
         sh_neur[l]  = 0;
      end

      applyStimulus();
      waitDone("post-reset empty");
      checkOutput("post-reset empty done cycle", done_rel, 4);

      writeCfg(0, 1, 4);
      applyStimulus();
      waitDone("1x4");
      checkOutput("1x4 done cycle", done_rel, 10);

      repeat (3) @(posedge clk);
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
